// File: rtl/sdf_stage_ctrl_pkg.sv
// Shared definitions for the SDF FFT stage controller: FSM states, datapath
// mode encodings and the per-stage delay-line length.
package sdf_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } fsm_e;

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_BF   = 2'd1;
  localparam logic [1:0] MODE_TW   = 2'd2;

  // Delay-line depth of a radix-2 SDF stage.
  function automatic int unsigned calc_delay(int unsigned n, int unsigned stage);
    return n >> (stage + 1);
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Upstream handshake and stage-datapath control bundle of one SDF stage.
interface sdf_stage_ctrl_if #(
  parameter  int unsigned N  = 1024,
  localparam int unsigned LN = $clog2(N)
);

  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          adv;
  logic [1:0]    mode;
  logic          out_valid;
  logic [LN-2:0] tw_addr;
  logic          frame_done;
  logic          frame_err;

  modport master (
    output in_valid, in_last,
    input  in_ready, adv, mode, out_valid, tw_addr, frame_done, frame_err
  );

  modport slave (
    input  in_valid, in_last,
    output in_ready, adv, mode, out_valid, tw_addr, frame_done, frame_err
  );

endinterface

// File: rtl/sdf_phase_decode.sv
// Combinational map from controller state and sample counter to datapath mode,
// output-valid and twiddle ROM index.
module sdf_phase_decode
  import sdf_stage_ctrl_pkg::*;
#(
  parameter  int unsigned N     = 1024,
  parameter  int unsigned STAGE = 0,
  localparam int unsigned LN    = $clog2(N)
) (
  input  fsm_e          fsm_i,
  input  logic [LN-1:0] cnt_i,
  input  logic          adv_i,
  output logic [1:0]    mode_o,
  output logic          out_valid_o,
  output logic [LN-2:0] tw_addr_o
);

  localparam int unsigned   D      = calc_delay(N, STAGE);
  localparam int unsigned   PhBit  = $clog2(D);
  localparam logic [LN-1:0] DCnt   = LN'(D);
  localparam logic [LN-2:0] DMask  = (LN-1)'(D - 1);

  logic [LN-2:0] tw_scaled;

  // D never exceeds N/2, so cnt mod D fits in the low LN-1 bits.
  assign tw_scaled = (cnt_i[LN-2:0] & DMask) << STAGE;

  always_comb begin
    mode_o      = MODE_FILL;
    out_valid_o = 1'b0;
    tw_addr_o   = '0;
    if (adv_i) begin
      unique case (fsm_i)
        StRun: begin
          if (cnt_i >= DCnt) begin
            out_valid_o = 1'b1;
            mode_o      = cnt_i[PhBit] ? MODE_BF : MODE_TW;
          end
        end
        StDrain: begin
          out_valid_o = 1'b1;
          mode_o      = MODE_TW;
        end
        default: ;
      endcase
    end
    if (mode_o == MODE_TW) begin
      tw_addr_o = tw_scaled;
    end
  end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: counts accepted samples, drives the
// stage datapath mode and drains the delay line after each frame.
module sdf_stage_ctrl
  import sdf_stage_ctrl_pkg::*;
#(
  parameter  int unsigned N     = 1024,
  parameter  int unsigned STAGE = 0,
  localparam int unsigned LN    = $clog2(N)
) (
  input logic              clk,
  input logic              rst_n,
  sdf_stage_ctrl_if.slave  bus
);

  localparam int unsigned   D       = calc_delay(N, STAGE);
  localparam logic [LN-1:0] CntOne  = LN'(1);
  localparam logic [LN-1:0] CntLast = LN'(N - 1);
  localparam logic [LN-1:0] DLast   = LN'(D - 1);

  fsm_e          fsm_q, fsm_d;
  logic [LN-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          adv;

  // No backpressure handling in DRAIN: the delay line empties at full rate.
  assign bus.in_ready   = (fsm_q != StDrain);
  assign adv            = (fsm_q == StDrain) | bus.in_valid;
  assign bus.adv        = adv;
  assign bus.frame_done = (fsm_q == StDrain) && (cnt_q == DLast);
  assign bus.frame_err  = err_q;

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (fsm_q)
      StIdle: begin
        if (bus.in_valid) begin
          cnt_d = CntOne;
          fsm_d = StRun;
          if (bus.in_last) err_d = 1'b1;
        end
      end
      StRun: begin
        if (bus.in_valid) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            fsm_d = StDrain;
            if (!bus.in_last) err_d = 1'b1;
          end else begin
            // Early in_last is flagged but the frame length stays N.
            cnt_d = cnt_q + CntOne;
            if (bus.in_last) err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (cnt_q == DLast) begin
          cnt_d = '0;
          fsm_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        fsm_d = StIdle;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= StIdle;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  sdf_phase_decode #(
    .N     (N),
    .STAGE (STAGE)
  ) u_phase_decode (
    .fsm_i       (fsm_q),
    .cnt_i       (cnt_q),
    .adv_i       (adv),
    .mode_o      (bus.mode),
    .out_valid_o (bus.out_valid),
    .tw_addr_o   (bus.tw_addr)
  );

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl at N=8 on stages 0, 1 and 2 (D=4, 2, 1).
module tb_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic vld;
  logic last;
  int   sel;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_count;

  int exp_mode [16];
  int exp_tw   [16];

  always #5 clk = ~clk;

  sdf_stage_ctrl_if #(.N(8)) if0 ();
  sdf_stage_ctrl_if #(.N(8)) if1 ();
  sdf_stage_ctrl_if #(.N(8)) if2 ();

  assign if0.in_valid = vld && (sel == 0);
  assign if1.in_valid = vld && (sel == 1);
  assign if2.in_valid = vld && (sel == 2);
  assign if0.in_last  = last;
  assign if1.in_last  = last;
  assign if2.in_last  = last;

  sdf_stage_ctrl #(.N(8), .STAGE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sdf_stage_ctrl #(.N(8), .STAGE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sdf_stage_ctrl #(.N(8), .STAGE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic       o_rdy, o_adv, o_ov, o_fd, o_err;
  logic [1:0] o_mode;
  logic [1:0] o_tw;

  always_comb begin
    case (sel)
      0: begin
        o_rdy = if0.in_ready; o_adv = if0.adv; o_mode = if0.mode; o_ov = if0.out_valid;
        o_tw = if0.tw_addr; o_fd = if0.frame_done; o_err = if0.frame_err;
      end
      1: begin
        o_rdy = if1.in_ready; o_adv = if1.adv; o_mode = if1.mode; o_ov = if1.out_valid;
        o_tw = if1.tw_addr; o_fd = if1.frame_done; o_err = if1.frame_err;
      end
      default: begin
        o_rdy = if2.in_ready; o_adv = if2.adv; o_mode = if2.mode; o_ov = if2.out_valid;
        o_tw = if2.tw_addr; o_fd = if2.frame_done; o_err = if2.frame_err;
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cycle_chk(input string tag, input int em, input int et, input bit rdy,
                           input bit fd, input bit adv);
    @(negedge clk);
    check_eq({tag, " mode"}, 32'(o_mode), em);
    check_eq({tag, " out_valid"}, 32'(o_ov), 32'(em != 0));
    check_eq({tag, " tw_addr"}, 32'(o_tw), et);
    check_eq({tag, " in_ready"}, 32'(o_rdy), 32'(rdy));
    check_eq({tag, " frame_done"}, 32'(o_fd), 32'(fd));
    check_eq({tag, " adv"}, 32'(o_adv), 32'(adv));
    if (o_ov === 1'b1) ov_count++;
    @(posedge clk);
    #1;
  endtask

  // Runs up to ncyc cycles of one frame; with stall set, every accepted
  // sample is followed by an in_valid=0 hole.
  task automatic run_frame(input string tag, input int s, input int d, input int last_idx,
                           input bit stall, input int ncyc);
    int  k    = 0;
    int  c    = 0;
    bit  hole = 1'b0;
    sel      = s;
    ov_count = 0;
    while (c < ncyc && k < 8 + d) begin
      if (k < 8) begin
        if (stall && hole) begin
          vld = 1'b0; last = 1'b0;
          cycle_chk({tag, " hole"}, 0, 0, 1'b1, 1'b0, 1'b0);
          hole = 1'b0;
        end else begin
          vld = 1'b1; last = (k == last_idx);
          cycle_chk($sformatf("%s s%0d", tag, k), exp_mode[k], exp_tw[k], 1'b1, 1'b0, 1'b1);
          k++;
          hole = stall;
        end
      end else begin
        // Upstream keeps offering a sample through the drain.
        vld = 1'b1; last = 1'b0;
        cycle_chk($sformatf("%s d%0d", tag, k - 8), exp_mode[k], exp_tw[k], 1'b0,
                  (k == 8 + d - 1), 1'b1);
        k++;
      end
      c++;
    end
    vld = 1'b0; last = 1'b0;
    if (k == 8 + d) begin
      cycle_chk({tag, " post"}, 0, 0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_stage0();
    exp_mode = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0, 0, 0};
    exp_tw   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; last = 1'b0; sel = 0;
    #3;
    check_eq("rst in_ready", 32'(o_rdy), 1);
    check_eq("rst adv", 32'(o_adv), 0);
    check_eq("rst mode", 32'(o_mode), 0);
    check_eq("rst out_valid", 32'(o_ov), 0);
    check_eq("rst tw_addr", 32'(o_tw), 0);
    check_eq("rst frame_done", 32'(o_fd), 0);
    check_eq("rst frame_err", 32'(o_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stage 0, D=4
    load_stage0();
    run_frame("t1", 0, 4, 7, 1'b0, 100);
    check_eq("t1 ov_count", ov_count, 8);
    check_eq("t1 frame_err", 32'(o_err), 0);

    // Stage 1, D=2
    exp_mode = '{0, 0, 1, 1, 2, 2, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0};
    exp_tw   = '{0, 0, 0, 0, 0, 2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
    run_frame("t2", 1, 2, 7, 1'b0, 100);
    check_eq("t2 ov_count", ov_count, 8);

    // Stage 2, D=1
    exp_mode = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    exp_tw   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("t3", 2, 1, 7, 1'b0, 100);
    check_eq("t3 ov_count", ov_count, 8);

    // Stalled stage 0 frame repeats the test-1 sequence
    load_stage0();
    run_frame("t4", 0, 4, 7, 1'b1, 100);
    check_eq("t4 ov_count", ov_count, 8);
    check_eq("t4 frame_err", 32'(o_err), 0);

    // Early in_last: error, frame still runs to 8 samples
    run_frame("t5a", 0, 4, 4, 1'b0, 100);
    check_eq("t5a frame_err", 32'(o_err), 1);
    pulse_reset();
    check_eq("t5 err cleared", 32'(o_err), 0);
    // Missing in_last: error, drain still entered
    run_frame("t5b", 0, 4, -1, 1'b0, 100);
    check_eq("t5b frame_err", 32'(o_err), 1);
    run_frame("t5c", 0, 4, 7, 1'b0, 100);
    check_eq("t5c err sticky", 32'(o_err), 1);
    pulse_reset();
    // Single-sample frame in IDLE
    vld = 1'b1; last = 1'b1;
    cycle_chk("t5d", 0, 0, 1'b1, 1'b0, 1'b1);
    vld = 1'b0; last = 1'b0;
    check_eq("t5d frame_err", 32'(o_err), 1);
    pulse_reset();

    // Reset mid-RUN at cnt=5
    run_frame("t6a", 0, 4, 7, 1'b0, 5);
    vld = 1'b1;
    #1;
    check_eq("t6a pre mode", 32'(o_mode), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6a rst mode", 32'(o_mode), 0);
    check_eq("t6a rst out_valid", 32'(o_ov), 0);
    check_eq("t6a rst in_ready", 32'(o_rdy), 1);
    vld = 1'b0;
    #1;
    check_eq("t6a rst adv", 32'(o_adv), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("t6b", 0, 4, 7, 1'b0, 100);
    check_eq("t6b ov_count", ov_count, 8);

    // Reset mid-DRAIN at cnt=2
    run_frame("t6c", 0, 4, 7, 1'b0, 10);
    #1;
    check_eq("t6c pre in_ready", 32'(o_rdy), 0);
    check_eq("t6c pre tw_addr", 32'(o_tw), 2);
    rst_n = 1'b0;
    #1;
    check_eq("t6c rst in_ready", 32'(o_rdy), 1);
    check_eq("t6c rst adv", 32'(o_adv), 0);
    check_eq("t6c rst mode", 32'(o_mode), 0);
    check_eq("t6c rst tw_addr", 32'(o_tw), 0);
    check_eq("t6c rst frame_done", 32'(o_fd), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("t6d", 0, 4, 7, 1'b0, 100);
    check_eq("t6d frame_err", 32'(o_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
